ls30rot_capture: RTL and testbench

Input-conditioning stage for the LS-30 rotary joystick, directly upstream of the rotation decoder. It synchronises the four grouped active-low switch lines, debounces them, converts them to positive logic, and rejects unusable patterns. It presents a current/previous pair plus a `wait_data` qualifier, so the decoder sees exactly one clean transition per accepted change.

---
 rtl/ls30rot_capture.sv | 122 ++++++++++++
 tb/tb_ls30rot_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ls30rot_capture.sv
// LS-30 rotary joystick input conditioning: synchronise, debounce, invert and
// qualify the four grouped switch lines for the downstream rotation decoder.
module ls30rot_capture #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] ls30_raw,
  output logic [3:0] curr_data,
  output logic [3:0] last_data,
  output logic       wait_data,
  output logic       invalid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]       sync;
  logic [1:0]       state, state_next;
  logic [3:0]       stable, stable_next;
  logic [3:0]       cand, cand_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       curr_next, last_next;
  logic             invalid_next;

  // Single contact or a cyclically adjacent pair of contacts.
  function automatic logic is_legal(input logic [3:0] p);
    case (p)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1001: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Inversion happens at the first flop, so reset value 0 means raw 1111.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ~ls30_raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      stable    <= 4'b0000;
      cand      <= 4'b0000;
      cnt       <= '0;
      curr_data <= 4'b0000;
      last_data <= 4'b0000;
      invalid   <= 1'b0;
      wait_data <= 1'b1;
    end else begin
      state     <= state_next;
      stable    <= stable_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      curr_data <= curr_next;
      last_data <= last_next;
      invalid   <= invalid_next;
      wait_data <= (state_next != IDLE);
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_next   = state;
    stable_next  = stable;
    cand_next    = cand;
    cnt_next     = cnt;
    curr_next    = curr_data;
    last_next    = last_data;
    invalid_next = 1'b0;
    case (state)
      IDLE: begin
        if (sync != stable) begin
          cand_next  = sync;
          cnt_next   = '0;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (sync != cand) begin
          cand_next = sync;
          cnt_next  = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = COMMIT;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      COMMIT: begin
        stable_next = cand;
        state_next  = IDLE;
        if (is_legal(cand)) begin
          if (cand != curr_data) begin
            last_next = curr_data;
            curr_next = cand;
          end
        end else if (cand != 4'b0000) begin
          invalid_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ls30rot_capture.sv
// Directed self-checking bench for ls30rot_capture at default parameters.
module tb_ls30rot_capture;

  logic       clk;
  logic       reset_n;
  logic [3:0] ls30_raw;
  logic [3:0] curr_data;
  logic [3:0] last_data;
  logic       wait_data;
  logic       invalid;

  int passed = 0;
  int total  = 0;

  int inv_seen  = 0;
  int wait_seen = 0;
  int commits   = 0;
  logic [3:0] curr_prev = 4'b0000;

  ls30rot_capture dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ls30_raw  (ls30_raw),
    .curr_data (curr_data),
    .last_data (last_data),
    .wait_data (wait_data),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle; tasks use deltas of these.
  always @(negedge clk) begin
    if (invalid === 1'b1) inv_seen++;
    if (wait_data === 1'b1) wait_seen++;
    if (curr_data !== curr_prev) begin
      commits++;
      curr_prev = curr_data;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int inv0;
    reset_n  = 1'b0;
    ls30_raw = 4'hF;
    hold(3);
    total++;
    if (wait_data !== 1'b1) $display("FAIL reset_wait: got %b want 1", wait_data);
    else passed++;
    total++;
    if (curr_data !== 4'b0000 || last_data !== 4'b0000)
      $display("FAIL reset_data: got %b/%b want 0000/0000", curr_data, last_data);
    else passed++;
    inv0 = inv_seen;
    reset_n = 1'b1;
    hold(1);
    total++;
    if (wait_data !== 1'b0) $display("FAIL reset_wait_fall: got %b want 0", wait_data);
    else passed++;
    hold(10);
    total++;
    if (curr_data !== 4'b0000 || last_data !== 4'b0000 || invalid !== 1'b0)
      $display("FAIL reset_idle: got %b/%b inv %b want 0000/0000 inv 0", curr_data, last_data, invalid);
    else passed++;
    total++;
    if (inv_seen != inv0) $display("FAIL reset_no_invalid: got %0d pulses want 0", inv_seen - inv0);
    else passed++;
  endtask

  task automatic test_single;
    logic exp_wait;
    ls30_raw = 4'hE;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      #1;
      exp_wait = (k >= 2 && k <= 18);
      total++;
      if (wait_data !== exp_wait) $display("FAIL single_wait_e%0d: got %b want %b", k, wait_data, exp_wait);
      else passed++;
      if (k == 18) begin
        total++;
        if (curr_data !== 4'b0000) $display("FAIL single_curr_e18: got %b want 0000", curr_data);
        else passed++;
      end
      if (k == 19) begin
        total++;
        if (curr_data !== 4'b0001 || last_data !== 4'b0000)
          $display("FAIL single_commit_e19: got %b/%b want 0001/0000", curr_data, last_data);
        else passed++;
      end
    end
  endtask

  task automatic test_rotation;
    int c0;
    c0 = commits;
    ls30_raw = 4'h6;
    hold(40);
    total++;
    if (curr_data !== 4'b1001 || last_data !== 4'b0001)
      $display("FAIL rot_step1: got %b/%b want 1001/0001", curr_data, last_data);
    else passed++;
    ls30_raw = 4'h7;
    hold(40);
    total++;
    if (curr_data !== 4'b1000 || last_data !== 4'b1001)
      $display("FAIL rot_step2: got %b/%b want 1000/1001", curr_data, last_data);
    else passed++;
    total++;
    if (commits - c0 != 2) $display("FAIL rot_commits: got %0d want 2", commits - c0);
    else passed++;
  endtask

  task automatic test_glitch;
    int c0, w0, i0;
    ls30_raw = 4'hE;
    hold(40);
    total++;
    if (curr_data !== 4'b0001 || last_data !== 4'b1000)
      $display("FAIL glitch_setup: got %b/%b want 0001/1000", curr_data, last_data);
    else passed++;
    c0 = commits; w0 = wait_seen; i0 = inv_seen;
    ls30_raw = 4'hD;
    hold(5);
    ls30_raw = 4'hE;
    hold(40);
    total++;
    if (curr_data !== 4'b0001 || last_data !== 4'b1000)
      $display("FAIL glitch_hold: got %b/%b want 0001/1000", curr_data, last_data);
    else passed++;
    total++;
    if (commits != c0) $display("FAIL glitch_commits: got %0d want 0", commits - c0);
    else passed++;
    total++;
    if (wait_seen - w0 < 16) $display("FAIL glitch_wait_pulse: got %0d cycles want >=16", wait_seen - w0);
    else passed++;
    total++;
    if (wait_data !== 1'b0 || inv_seen != i0)
      $display("FAIL glitch_end: got wait %b inv %0d want wait 0 inv 0", wait_data, inv_seen - i0);
    else passed++;
  endtask

  task automatic test_invalid;
    int c0, i0;
    c0 = commits; i0 = inv_seen;
    ls30_raw = 4'hA;
    hold(40);
    total++;
    if (inv_seen - i0 != 1) $display("FAIL inv_opposite: got %0d pulses want 1", inv_seen - i0);
    else passed++;
    ls30_raw = 4'h0;
    hold(40);
    total++;
    if (inv_seen - i0 != 2) $display("FAIL inv_all_set: got %0d pulses want 2", inv_seen - i0);
    else passed++;
    total++;
    if (curr_data !== 4'b0001 || last_data !== 4'b1000 || commits != c0)
      $display("FAIL inv_hold: got %b/%b commits %0d want 0001/1000 commits 0", curr_data, last_data, commits - c0);
    else passed++;
    ls30_raw = 4'hE;
    hold(40);
    total++;
    if (curr_data !== 4'b0001 || inv_seen - i0 != 2)
      $display("FAIL inv_return: got %b inv %0d want 0001 inv 2", curr_data, inv_seen - i0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    ls30_raw = 4'hB;
    hold(11);
    reset_n = 1'b0;
    #1;
    total++;
    if (curr_data !== 4'b0000 || last_data !== 4'b0000 || wait_data !== 1'b1)
      $display("FAIL midreset_values: got %b/%b wait %b want 0000/0000 wait 1", curr_data, last_data, wait_data);
    else passed++;
    hold(2);
    reset_n = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 || k == 2) begin
        total++;
        if (wait_data !== (k == 2)) $display("FAIL midreset_wait_e%0d: got %b want %b", k, wait_data, (k == 2));
        else passed++;
      end
      if (k == 18) begin
        total++;
        if (curr_data !== 4'b0000) $display("FAIL midreset_e18: got %b want 0000", curr_data);
        else passed++;
      end
      if (k == 19) begin
        total++;
        if (curr_data !== 4'b0100 || last_data !== 4'b0000 || wait_data !== 1'b0)
          $display("FAIL midreset_e19: got %b/%b wait %b want 0100/0000 wait 0", curr_data, last_data, wait_data);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    ls30_raw = 4'h9;
    for (int k = 0; k <= 38; k++) begin
      @(posedge clk);
      #1;
      if (k == 17) ls30_raw = 4'hD;
      if (k == 19) begin
        total++;
        if (curr_data !== 4'b0110 || last_data !== 4'b0100)
          $display("FAIL b2b_first: got %b/%b want 0110/0100", curr_data, last_data);
        else passed++;
      end
      if (k == 36) begin
        total++;
        if (curr_data !== 4'b0110 || wait_data !== 1'b1)
          $display("FAIL b2b_e36: got %b wait %b want 0110 wait 1", curr_data, wait_data);
        else passed++;
      end
      if (k == 37) begin
        total++;
        if (curr_data !== 4'b0010 || last_data !== 4'b0110 || wait_data !== 1'b0)
          $display("FAIL b2b_second: got %b/%b wait %b want 0010/0110 wait 0", curr_data, last_data, wait_data);
        else passed++;
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    ls30_raw = 4'hF;
    test_reset();
    test_single();
    test_rotation();
    test_glitch();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
